// File: rtl/mips_cpu_bus_run_monitor.sv
// Run controller and Avalon-master checker for mips_cpu_bus; every output is registered (1-cycle latency).
// Purely observes the bus and never stalls it; waitrequest belongs to the slave.
module mips_cpu_bus_run_monitor #(
    parameter int RESET_CYCLES   = 1,
    parameter int ACTIVE_WINDOW  = 2,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int SETTLE_CYCLES  = 1,
    parameter int MAX_WAIT       = 64,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             cpu_reset,
    input  logic             active,
    input  logic [31:0]      register_v0,
    input  logic [31:0]      address,
    input  logic             read,
    input  logic             write,
    input  logic [3:0]       byteenable,
    input  logic [31:0]      writedata,
    input  logic             waitrequest,
    output logic             done,
    output logic [2:0]       status,
    output logic [2:0]       error_code,
    output logic [31:0]      result_v0,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] S_HOLD   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    localparam logic [2:0] ST_HALTED    = 3'd1;
    localparam logic [2:0] ST_TIMEOUT   = 3'd2;
    localparam logic [2:0] ST_NO_ACTIVE = 3'd3;
    localparam logic [2:0] ST_PROTO     = 3'd4;

    logic [2:0]       state;
    logic [31:0]      phase_cnt;
    logic [31:0]      wait_cnt;
    logic             sh_stall;
    logic             sh_read;
    logic             sh_write;
    logic [31:0]      sh_address;
    logic [3:0]       sh_byteenable;
    logic [31:0]      sh_writedata;

    logic             req;
    logic             stall;
    logic             checking;
    logic             unstable;
    logic [31:0]      wait_next;
    logic [2:0]       proto_code;
    logic [CNT_W-1:0] cnt_next;

    assign req       = read | write;
    assign stall     = req & waitrequest;
    assign checking  = (state == S_RUN) || (state == S_SETTLE);
    assign wait_next = stall ? wait_cnt + 32'd1 : 32'd0;
    assign cnt_next  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

    // A stalled transfer must be held bit-for-bit until the slave releases it.
    assign unstable = sh_stall &&
                      ((read != sh_read) || (write != sh_write) ||
                       (address != sh_address) || (byteenable != sh_byteenable) ||
                       (write && (writedata != sh_writedata)));

    always_comb begin
        proto_code = 3'd0;
        if (read && write)
            proto_code = 3'd1;
        else if (req && (byteenable == 4'd0))
            proto_code = 3'd2;
        else if (req && (address[1:0] != 2'd0))
            proto_code = 3'd3;
        else if (unstable)
            proto_code = 3'd4;
        else if (wait_next > 32'(MAX_WAIT))
            proto_code = 3'd5;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_HOLD;
            cpu_reset     <= 1'b1;
            done          <= 1'b0;
            status        <= 3'd0;
            error_code    <= 3'd0;
            result_v0     <= 32'd0;
            cycle_count   <= '0;
            phase_cnt     <= 32'd0;
            wait_cnt      <= 32'd0;
            sh_stall      <= 1'b0;
            sh_read       <= 1'b0;
            sh_write      <= 1'b0;
            sh_address    <= 32'd0;
            sh_byteenable <= 4'd0;
            sh_writedata  <= 32'd0;
        end else begin
            if (checking) begin
                sh_stall      <= stall;
                sh_read       <= read;
                sh_write      <= write;
                sh_address    <= address;
                sh_byteenable <= byteenable;
                sh_writedata  <= writedata;
                wait_cnt      <= wait_next;
            end else begin
                sh_stall      <= 1'b0;
                sh_read       <= 1'b0;
                sh_write      <= 1'b0;
                sh_address    <= 32'd0;
                sh_byteenable <= 4'd0;
                sh_writedata  <= 32'd0;
                wait_cnt      <= 32'd0;
            end

            // phase_cnt is reused as the hold, active-window and settle counter.
            case (state)
                S_HOLD: begin
                    if (phase_cnt == 32'(RESET_CYCLES - 1)) begin
                        cpu_reset <= 1'b0;
                        phase_cnt <= 32'd0;
                        state     <= S_WAIT;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (active) begin
                        phase_cnt <= 32'd0;
                        state     <= S_RUN;
                    end else if (phase_cnt == 32'(ACTIVE_WINDOW - 1)) begin
                        state     <= S_FAIL;
                        done      <= 1'b1;
                        cpu_reset <= 1'b1;
                        status    <= ST_NO_ACTIVE;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    cycle_count <= cnt_next;
                    if (proto_code != 3'd0) begin
                        state      <= S_FAIL;
                        done       <= 1'b1;
                        cpu_reset  <= 1'b1;
                        status     <= ST_PROTO;
                        error_code <= proto_code;
                    end else if (!active) begin
                        phase_cnt <= 32'd0;
                        state     <= S_SETTLE;
                    end else if (cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
                        state     <= S_FAIL;
                        done      <= 1'b1;
                        cpu_reset <= 1'b1;
                        status    <= ST_TIMEOUT;
                    end
                end
                S_SETTLE: begin
                    if (proto_code != 3'd0) begin
                        state      <= S_FAIL;
                        done       <= 1'b1;
                        cpu_reset  <= 1'b1;
                        status     <= ST_PROTO;
                        error_code <= proto_code;
                    end else if (phase_cnt == 32'(SETTLE_CYCLES)) begin
                        result_v0 <= register_v0;
                        state     <= S_DONE;
                        done      <= 1'b1;
                        status    <= ST_HALTED;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end
                S_DONE, S_FAIL: begin
                end
                default: begin
                    state     <= S_HOLD;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_run_monitor.sv
// Scoreboard bench: each scenario is a per-edge input table; a reference walk of the rules predicts the
// terminal outcome, and a monitor pops and compares it when done rises.
module tb_mips_cpu_bus_run_monitor;

    localparam int RC   = 1;
    localparam int AW   = 2;
    localparam int TO   = 80;
    localparam int SC   = 1;
    localparam int MW   = 64;
    localparam int MAXC = 220;

    logic        clk;
    logic        reset;
    logic        cpu_reset;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic        done;
    logic [2:0]  status;
    logic [2:0]  error_code;
    logic [31:0] result_v0;
    logic [31:0] cycle_count;

    mips_cpu_bus_run_monitor #(
        .RESET_CYCLES(RC), .ACTIVE_WINDOW(AW), .TIMEOUT_CYCLES(TO),
        .SETTLE_CYCLES(SC), .MAX_WAIT(MW), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .cpu_reset(cpu_reset), .active(active),
        .register_v0(register_v0), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
        .done(done), .status(status), .error_code(error_code),
        .result_v0(result_v0), .cycle_count(cycle_count)
    );

    typedef struct {
        int          edge_k;
        logic [2:0]  st;
        logic [2:0]  err;
        logic [31:0] v0;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Stimulus tables indexed by clock edge counted from reset release (edge 1 = first edge with reset low).
    logic        a_act[0:MAXC];
    logic        a_rd[0:MAXC];
    logic        a_wr[0:MAXC];
    logic        a_wt[0:MAXC];
    logic [31:0] a_addr[0:MAXC];
    logic [31:0] a_wd[0:MAXC];
    logic [31:0] a_v0[0:MAXC];
    logic [3:0]  a_be[0:MAXC];

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;
    bit mon_en   = 0;
    logic done_q = 1'b0;
    logic cr_q   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= reset ? 0 : edge_no + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic clear_stim(input bit rnd_v0, input logic [31:0] v0c);
        for (int k = 0; k <= MAXC; k++) begin
            a_act[k] = 1'b0; a_rd[k] = 1'b0; a_wr[k] = 1'b0; a_wt[k] = 1'b0;
            a_addr[k] = 32'd0; a_wd[k] = 32'd0; a_be[k] = 4'd0;
            a_v0[k] = rnd_v0 ? $urandom : v0c;
        end
    endtask

    task automatic set_xfer(input int k, input logic r, input logic w, input logic [31:0] ad,
                            input logic [3:0] be, input logic wt);
        if (k <= MAXC) begin
            a_rd[k] = r; a_wr[k] = w; a_addr[k] = ad; a_be[k] = be; a_wt[k] = wt;
        end
    endtask

    // active seen first at edge RC+d, then held for run_len edges; legal traffic only while active.
    task automatic gen_run(input int d, input int run_len, input bit traffic);
        int s, k, w;
        logic isw;
        logic [31:0] ad, wd;
        logic [3:0] be;
        s = RC + d;
        for (int j = s; j < s + run_len && j <= MAXC; j++) a_act[j] = 1'b1;
        if (traffic) begin
            k = s + 1;
            while (k < s + run_len && k <= MAXC) begin
                if ($urandom_range(0, 3) == 0) begin
                    k++;
                end else begin
                    w = $urandom_range(0, 2);
                    if (k + w >= s + run_len) break;
                    isw = 1'($urandom_range(0, 1));
                    ad  = 32'($urandom_range(0, 1023)) << 2;
                    be  = 4'($urandom_range(1, 15));
                    wd  = $urandom;
                    for (int j = 0; j <= w; j++) begin
                        set_xfer(k + j, !isw, isw, ad, be, j < w);
                        if (k + j <= MAXC) a_wd[k + j] = wd;
                    end
                    k = k + w + 1;
                end
            end
        end
    endtask

    task automatic mutate(input int k, input int m);
        if (k <= MAXC) begin
            case (m)
                1: begin a_rd[k] = 1'b1; a_wr[k] = 1'b1; if (a_be[k] == 4'd0) a_be[k] = 4'hF; end
                2: begin if (!a_wr[k]) a_rd[k] = 1'b1; a_be[k] = 4'd0; end
                3: begin if (!a_wr[k]) a_rd[k] = 1'b1; a_be[k] = 4'h3; a_addr[k] = a_addr[k] | 32'h1; end
                4: a_addr[k] = a_addr[k] ^ 32'h10;
                default: ;
            endcase
        end
    endtask

    // Reference: find when active appears, then walk RUN/SETTLE applying the bus rules to each edge.
    function automatic exp_t model();
        exp_t e;
        int k, runc, sc, waitc, code;
        bit in_run, pst, rq;
        logic prd, pwr;
        logic [31:0] pad, pwd;
        logic [3:0] pbe;
        e.edge_k = -1; e.st = 3'd0; e.err = 3'd0; e.v0 = 32'd0; e.cnt = 32'd0;
        k = 0;
        for (int j = 1; j <= AW; j++) if (k == 0 && a_act[RC + j]) k = RC + j;
        if (k == 0) begin
            e.edge_k = RC + AW; e.st = 3'd3;
            return e;
        end
        in_run = 1; runc = 0; sc = 0; waitc = 0; pst = 0;
        prd = 0; pwr = 0; pad = 0; pwd = 0; pbe = 0;
        for (int n = k + 1; n <= MAXC; n++) begin
            rq    = a_rd[n] | a_wr[n];
            waitc = (rq && a_wt[n]) ? waitc + 1 : 0;
            code  = 0;
            if (a_rd[n] && a_wr[n]) code = 1;
            else if (rq && a_be[n] == 4'd0) code = 2;
            else if (rq && a_addr[n][1:0] != 2'd0) code = 3;
            else if (pst && (a_rd[n] != prd || a_wr[n] != pwr || a_addr[n] != pad ||
                             a_be[n] != pbe || (a_wr[n] && a_wd[n] != pwd))) code = 4;
            else if (waitc > MW) code = 5;
            if (in_run) runc++;
            e.cnt = 32'(runc);
            if (code != 0) begin
                e.edge_k = n; e.st = 3'd4; e.err = 3'(code);
                return e;
            end
            if (in_run) begin
                if (!a_act[n]) in_run = 0;
                else if (runc == TO) begin
                    e.edge_k = n; e.st = 3'd2;
                    return e;
                end
            end else if (sc == SC) begin
                e.edge_k = n; e.st = 3'd1; e.v0 = a_v0[n];
                return e;
            end else begin
                sc++;
            end
            pst = rq && a_wt[n];
            prd = a_rd[n]; pwr = a_wr[n]; pad = a_addr[n]; pwd = a_wd[n]; pbe = a_be[n];
        end
        return e;
    endfunction

    task automatic drive(input int k);
        if (k <= MAXC) begin
            active = a_act[k]; read = a_rd[k]; write = a_wr[k]; waitrequest = a_wt[k];
            address = a_addr[k]; writedata = a_wd[k]; byteenable = a_be[k]; register_v0 = a_v0[k];
        end else begin
            active = 1'b0; read = 1'b0; write = 1'b0; waitrequest = 1'b0;
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_error_code", 32'(error_code), 32'd0);
        chk("rst_result_v0", result_v0, 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        reset = 1'b0;
    endtask

    // stop_at > 0: run only that many edges and leave the DUT mid-flight.
    task automatic run_scn(input int stop_at);
        exp_t e;
        int ncyc;
        e = model();
        apply_reset(2);
        if (stop_at == 0 && e.edge_k > 0) begin
            exp_q.push_back(e);
            ncyc = e.edge_k + 3;
        end else begin
            ncyc = (stop_at > 0) ? stop_at : 150;
        end
        for (int k = 1; k <= ncyc; k++) begin
            drive(k);
            @(posedge clk);
            @(negedge clk);
        end
        if (stop_at == 0 && e.edge_k > 0) begin
            chk("done_within_budget", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_status", 32'(status), 32'(e.st));
            chk("hold_error_code", 32'(error_code), 32'(e.err));
            chk("hold_cycle_count", cycle_count, e.cnt);
            chk("hold_result_v0", result_v0, e.v0);
            chk("hold_cpu_reset", 32'(cpu_reset), 32'(e.st != 3'd1));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done && !done_q) begin
                    chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("done_edge", 32'(edge_no), 32'(mon_e.edge_k));
                        chk("status", 32'(status), 32'(mon_e.st));
                        chk("error_code", 32'(error_code), 32'(mon_e.err));
                        chk("result_v0", result_v0, mon_e.v0);
                        chk("cycle_count", cycle_count, mon_e.cnt);
                        chk("cpu_reset_at_done", 32'(cpu_reset), 32'(mon_e.st != 3'd1));
                    end
                end
                if (!cpu_reset && cr_q) chk("cpu_reset_fall_edge", 32'(edge_no), 32'(RC));
            end
            done_q = done;
            cr_q   = cpu_reset;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d, len, m, n;
        reset = 1'b1; active = 1'b0; read = 1'b0; write = 1'b0; waitrequest = 1'b0;
        address = 32'd0; writedata = 32'd0; byteenable = 4'd0; register_v0 = 32'd0;
        apply_reset(2);
        mon_en = 1;

        // clean halt, v0 = 0x1234, 50 RUN cycles
        clear_stim(0, 32'h0000_1234); gen_run(1, 50, 1); run_scn(0);
        // active never rises
        clear_stim(1, 32'd0); run_scn(0);
        // timeout, then active falling exactly on the timeout cycle
        clear_stim(1, 32'd0); gen_run(1, 200, 1); run_scn(0);
        clear_stim(1, 32'd0); gen_run(2, TO, 1); run_scn(0);
        // misaligned read; read&write with be=0
        clear_stim(1, 32'd0); gen_run(1, 40, 0); set_xfer(RC + 1 + 5, 1, 0, 32'h2, 4'hF, 0); run_scn(0);
        clear_stim(1, 32'd0); gen_run(1, 40, 0); set_xfer(RC + 1 + 5, 1, 1, 32'h10, 4'h0, 0); run_scn(0);
        // address changes under stall; stall longer than MAX_WAIT
        clear_stim(1, 32'd0); gen_run(1, 40, 0);
        set_xfer(RC + 1 + 5, 1, 0, 32'h100, 4'hF, 1); set_xfer(RC + 1 + 6, 1, 0, 32'h104, 4'hF, 1);
        run_scn(0);
        clear_stim(1, 32'd0); gen_run(1, 200, 0);
        for (int j = 3; j <= 72; j++) set_xfer(RC + 1 + j, 1, 0, 32'h40, 4'hF, 1);
        run_scn(0);
        // protocol error during SETTLE keeps result_v0 at 0
        clear_stim(1, 32'd0); gen_run(1, 20, 0); set_xfer(RC + 1 + 21, 1, 0, 32'h6, 4'hF, 0); run_scn(0);
        // reset at RUN cycle 30, then a clean run
        clear_stim(1, 32'd0); gen_run(1, 50, 1); run_scn(RC + 1 + 30); apply_reset(1);
        clear_stim(1, 32'd0); gen_run(2, 25, 1); run_scn(0);

        for (int it = 0; it < 10; it++) begin
            d   = $urandom_range(1, AW + 1);
            len = $urandom_range(2, 40);
            m   = $urandom_range(0, 5);
            n   = $urandom_range(1, len + 2);
            clear_stim(1, 32'd0);
            gen_run(d, len, 1);
            mutate(RC + d + n, m);
            run_scn(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_run_monitor.md
Name: mips_cpu_bus_run_monitor

Overview:
Synthesisable run controller and bus checker for the Avalon-bus MIPS CPU harness. It replaces fixed testbench sequencing with parametrised hardware:
- Sequences CPU reset.
- Checks `active` comes up.
- Enforces a cycle timeout.
- Checks Avalon master protocol on every cycle.
- Captures `register_v0` after halt with a completion status.

It sits between the bench/top-level and `mips_cpu_bus`, observing its bus alongside the RAM.

Parameters:
- RESET_CYCLES, 1, cycles `cpu_reset` is held after `reset` deasserts (>=1).
- ACTIVE_WINDOW, 2, cycles allowed for `active`=1 after `cpu_reset` falls (>=1).
- TIMEOUT_CYCLES, 10000, maximum RUN cycles before timeout (>=1).
- SETTLE_CYCLES, 1, cycles after halt before `register_v0` is sampled (>=0).
- MAX_WAIT, 64, maximum consecutive `waitrequest` cycles on one transfer.
- CNT_W, 32, width of `cycle_count`.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high monitor reset
- cpu_reset  output  1  reset driven to CPU
- active  input  1  CPU active flag
- register_v0  input  32  CPU v0 debug output
- address  input  32  CPU bus address
- read  input  1  CPU read request
- write  input  1  CPU write request
- byteenable  input  4  CPU byte enables
- writedata  input  32  CPU write data
- waitrequest  input  1  slave stall
- done  output  1  terminal state reached
- status  output  3  0 BUSY, 1 HALTED, 2 TIMEOUT, 3 NO_ACTIVE, 4 PROTOCOL_ERR
- error_code  output  3  0 none, 1 read&write, 2 byteenable=0, 3 misaligned, 4 unstable under wait, 5 wait overrun
- result_v0  output  32  captured v0
- cycle_count  output  CNT_W  RUN cycles elapsed, saturating

Behaviour:
- Reset: one clock with `reset`=1 forces, next cycle, state RESET_HOLD with:
  - `cpu_reset`=1, `done`=0, `status`=0, `error_code`=0, `result_v0`=0, `cycle_count`=0;
  - all internal counters and the stability shadow cleared.
- Reset mid-operation (any state) gives the same result; nothing is retained.
- RESET_HOLD: counts clocks with `reset`=0. After RESET_CYCLES such clocks, `cpu_reset`=0 and the state goes to WAIT_ACTIVE.
- WAIT_ACTIVE:
  - `active`=1 sampled -> RUN.
  - ACTIVE_WINDOW cycles elapse without it -> FAIL with `status`=3.
- RUN:
  - `cycle_count` increments every RUN cycle, saturating at all-ones.
  - Transition priority, highest first, in the same cycle: protocol error -> FAIL `status`=4; `active`=0 -> SETTLE; `cycle_count`==TIMEOUT_CYCLES with `active`=1 -> FAIL `status`=2.
- SETTLE:
  - Waits SETTLE_CYCLES cycles; with 0, the next cycle samples immediately.
  - On the final cycle, `result_v0`<=`register_v0`, then DONE.
  - Protocol checks stay enabled; an error here -> FAIL `status`=4, `result_v0` not updated.
- DONE: `done`=1, `status`=1, `cpu_reset`=0. Outputs are held until `reset`.
- FAIL:
  - `done`=1 and `cpu_reset`=1, freezing the CPU.
  - `status`, `error_code` and `cycle_count` are frozen; sticky until `reset`.
- Protocol checks, evaluated in RUN and SETTLE only, on the sampled inputs of the current cycle:
  - code 1: `read` and `write` both 1.
  - code 2: `read` or `write` with `byteenable`==0.
  - code 3: `read` or `write` with `address[1:0]`!=0.
  - code 4: previous cycle had (`read`|`write`)&&`waitrequest`, and this cycle `read`, `write`, `address` or `byteenable` differ, or `writedata` differs while `write`.
  - code 5: consecutive (`read`|`write`)&&`waitrequest` cycles exceed MAX_WAIT. The counter clears on any cycle without that condition.
- Error priority: several errors in one cycle record the lowest code. Only the first error cycle is recorded.
- Latency: every output is registered, so the effect is visible one cycle after the sampling edge.
- No combinational path from inputs to outputs.

Test Plan:
- RESET_CYCLES=1: `reset` high 2 cycles then low; `active`=1 one cycle after `cpu_reset` falls; CPU performs aligned reads (be=4'hF, waitrequest 0–2 cycles); `active`=0 after 50 RUN cycles with `register_v0`=32'h0000_1234, SETTLE_CYCLES=1 -> `done`=1, `status`=1, `result_v0`=32'h1234, `cycle_count`=50, `error_code`=0.
- `active` held 0, ACTIVE_WINDOW=2 -> exactly 2 cycles after `cpu_reset` falls, `status`=3, `cpu_reset`=1.
- TIMEOUT_CYCLES=20, `active` stays 1 -> `status`=2, `cycle_count`=20. Variant: `active` falls on the timeout cycle -> `status`=1.
- Read at address 32'h0000_0002 -> `status`=4, `error_code`=3. Variant: `read`&`write` with be=0 in the same cycle -> `error_code`=1.
- Read with `waitrequest` high, address changes during stall -> `error_code`=4. Variant: `waitrequest` held 65 cycles with MAX_WAIT=64 -> `error_code`=5.
- `reset` asserted during RUN at cycle 30 -> next cycle `cpu_reset`=1, `cycle_count`=0, `status`=0. A subsequent clean run completes with `status`=1.
